// File: rtl/rc_pulse_scheduler.sv
// rc_pulse_scheduler
//   Round-robin reader for a bank of pulse_buffer FIFOs. Pops one edge record
//   at a time, pairs rising/falling edges per channel into a high-time width,
//   and publishes it on a valid/ready stream and in a latest-width register file.
//
// Ports
//   clk, resetn             clock, async active-low reset
//   buf_rdy  [NUM_CH]       per-channel FIFO non-empty
//   buf_data [NUM_CH*32]    per-channel FIFO output ({level, ts[30:0]}), one cycle after rd
//   buf_rd   [NUM_CH]       per-channel pop strobe (one-hot or zero)
//   out_valid/out_ready     width stream handshake; out_ch / out_width payload
//   width_addr/width_data   registered latest-width read port (1-cycle latency)
//   err_count               saturating count of edge-sequence errors
//   chan_lost [NUM_CH]      per-channel signal-loss flags
//
// Build option
//   RC_PULSE_SCHED_TIMEOUT_EN : per-channel idle counters drive chan_lost;
//                               otherwise chan_lost is tied low.

`ifdef RC_PULSE_SCHED_TIMEOUT_EN
// Per-channel idle counter: cleared on an emitted width, otherwise counts up
// and saturates; lost is raised when the count reaches TIMEOUT_CYCLES.
module rc_pulse_sched_timeout #(
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic emit,
  output logic lost
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      lost <= 1'b1;
    end else if (emit) begin
      cnt  <= '0;
      lost <= 1'b0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == LIMIT - 1'b1) lost <= 1'b1;
    end
  end
endmodule
`endif

module rc_pulse_scheduler #(
  parameter int NUM_CH         = 8,
  parameter int CH_W           = 3,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_CH-1:0]    buf_rdy,
  input  logic [NUM_CH*32-1:0] buf_data,
  output logic [NUM_CH-1:0]    buf_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_ch,
  output logic [30:0]          out_width,
  input  logic [CH_W-1:0]      width_addr,
  output logic [30:0]          width_data,
  output logic [15:0]          err_count,
  output logic [NUM_CH-1:0]    chan_lost
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_PROC, S_EMIT} state_t;
  typedef struct packed {
    logic        level;
    logic [30:0] ts;
  } edge_rec_t;

  localparam logic [CH_W:0]   NUM_CH_L = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  state_t                  state, state_nxt;
  logic [CH_W-1:0]         ptr, gnt, arb_idx, ptr_nxt;
  logic                    arb_any;
  edge_rec_t               rec;
  logic [NUM_CH-1:0]       armed;
  logic [NUM_CH-1:0][30:0] rise_ts, latest;
  logic [NUM_CH-1:0][31:0] buf_words;
  logic [30:0]             width_calc;
  logic                    emit_now;

  assign buf_words  = buf_data;
  // 31-bit subtract gives the width modulo 2^31, covering timestamp wrap
  assign width_calc = rec.ts - rise_ts[gnt];
  assign emit_now   = (state == S_PROC) && !rec.level && armed[gnt];
  assign ptr_nxt    = (arb_idx == LAST_CH) ? '0 : arb_idx + 1'b1;

  // First ready channel at or after ptr, modulo NUM_CH. Scanning downward
  // lets the nearest candidate overwrite farther ones.
  always_comb begin
    logic [CH_W:0] idx;
    idx     = '0;
    arb_any = 1'b0;
    arb_idx = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (CH_W+1)'(i);
      if (idx >= NUM_CH_L) idx = idx - NUM_CH_L;
      if (buf_rdy[idx[CH_W-1:0]]) begin
        arb_any = 1'b1;
        arb_idx = idx[CH_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (arb_any) state_nxt = S_READ;
      S_READ:  state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_PROC;
      S_PROC:  state_nxt = emit_now ? S_EMIT : S_IDLE;
      S_EMIT:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    buf_rd    = '0;
    out_valid = 1'b0;
    if (state == S_READ) buf_rd[gnt] = 1'b1;
    if (state == S_EMIT) out_valid   = 1'b1;
  end

  // Grant latch, record capture and per-channel pairing state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr       <= '0;
      gnt       <= '0;
      rec       <= '0;
      armed     <= '0;
      rise_ts   <= '0;
      latest    <= '0;
      out_ch    <= '0;
      out_width <= '0;
      err_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (arb_any) begin
          gnt <= arb_idx;
          ptr <= ptr_nxt;
        end
        S_WAIT: rec <= buf_words[gnt];
        S_PROC: begin
          if (rec.level) begin
            // a second rise while armed means the fall was lost
            rise_ts[gnt] <= rec.ts;
            armed[gnt]   <= 1'b1;
            if (armed[gnt] && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
          end else if (armed[gnt]) begin
            latest[gnt] <= width_calc;
            armed[gnt]  <= 1'b0;
            out_ch      <= gnt;
            out_width   <= width_calc;
          end else if (err_count != 16'hFFFF) begin
            err_count <= err_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read sees the pre-write value when PROC updates the same entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) width_data <= '0;
    else         width_data <= latest[width_addr];
  end

`ifdef RC_PULSE_SCHED_TIMEOUT_EN
  for (genvar k = 0; k < NUM_CH; k++) begin : g_to
    rc_pulse_sched_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_to (
      .clk    (clk),
      .resetn (resetn),
      .emit   (emit_now && (gnt == CH_W'(k))),
      .lost   (chan_lost[k])
    );
  end
`else
  assign chan_lost = '0;
`endif

endmodule
